// File: rtl/alu_cmd_parser.sv
// alu_cmd_parser: byte-stream command parser sitting between a UART receiver
// and transmitter. Packets are {opcode, reserved, LEN[7:0], LEN[15:8],
// payload}; ECHO returns the payload, ADD (and optionally MUL) folds the
// payload into a 32-bit little-endian accumulator and returns it LSB first.
// Optional feature macro: ALU_CMD_MUL_EN enables opcode 0xB4 (MUL); when it is
// undefined no multiplier is built and 0xB4 is handled as an unknown opcode.
module alu_cmd_parser #(
  parameter int OPERAND_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i
);

  localparam int ACC_W = 8 * OPERAND_BYTES;
  localparam int IDX_W = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(OPERAND_BYTES - 1);

  localparam logic [2:0] S_OPCODE  = 3'd0;
  localparam logic [2:0] S_RSVD    = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_LEN_HI  = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_RESULT  = 3'd5;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA5;
`ifdef ALU_CMD_MUL_EN
  localparam logic [7:0] OP_MUL  = 8'hB4;
`endif

  // Control state
  logic [2:0]       r_state;
  logic             r_live;       // low during reset and the cycle after it
  logic [15:0]      r_cnt;        // payload bytes still to accept
  logic [IDX_W-1:0] r_idx;        // byte lane of the operand being assembled
  logic [IDX_W-1:0] r_res_idx;    // result byte currently presented
  logic             r_valid;
  logic [7:0]       r_data;

  // Datapath state
  logic [7:0]       r_opcode;
  logic [7:0]       r_len_lo;
  logic [ACC_W-1:0] r_operand;
  logic [ACC_W-1:0] r_acc;

  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_is_echo;
  logic             w_is_add;
  logic             w_is_mul;
  logic             w_is_arith;
  logic [15:0]      w_len;
  logic             w_len_empty;
  logic             w_last;
  logic [ACC_W-1:0] w_operand;
  logic             w_apply;
  logic [ACC_W-1:0] w_acc_step;
  logic [ACC_W-1:0] w_acc_init;
  logic [ACC_W-1:0] w_acc_next;
  logic [IDX_W-1:0] w_next_res_idx;
  logic [7:0]       w_res_byte;

  assign w_in_xfer   = valid_i && ready_o;
  assign w_out_xfer  = r_valid && ready_i;
  assign w_is_echo   = (r_opcode == OP_ECHO);
  assign w_is_add    = (r_opcode == OP_ADD);
  assign w_is_arith  = w_is_add || w_is_mul;
  assign w_len       = {data_i, r_len_lo};
  assign w_len_empty = (w_len <= 16'd4);
  assign w_last      = (r_cnt == 16'd1);

  // Current byte merged into the partially assembled operand; upper lanes
  // still hold zero, which is the zero-extension of a trailing short operand.
  assign w_operand = r_operand | (ACC_W'(data_i) << {r_idx, 3'b000});
  assign w_apply   = (r_state == S_PAYLOAD) && w_in_xfer && w_is_arith &&
                     ((r_idx == IDX_MAX) || w_last);

`ifdef ALU_CMD_MUL_EN
  assign w_is_mul = (r_opcode == OP_MUL);

  function automatic logic [ACC_W-1:0] apply_op(input logic [ACC_W-1:0] acc,
                                                input logic [ACC_W-1:0] opnd,
                                                input logic             is_mul);
    return is_mul ? (acc * opnd) : (acc + opnd);
  endfunction

  assign w_acc_step = apply_op(r_acc, w_operand, w_is_mul);
`else
  assign w_is_mul = 1'b0;

  function automatic logic [ACC_W-1:0] apply_op(input logic [ACC_W-1:0] acc,
                                                input logic [ACC_W-1:0] opnd);
    return acc + opnd;
  endfunction

  assign w_acc_step = apply_op(r_acc, w_operand);
`endif

  assign w_acc_init     = w_is_mul ? ACC_W'(1) : '0;
  assign w_next_res_idx = r_res_idx + 1'b1;
  assign w_res_byte     = 8'(r_acc >> {w_next_res_idx, 3'b000});

  // Accumulator next value: seeded when the header completes, folded per operand
  always_comb begin
    w_acc_next = r_acc;
    if ((r_state == S_LEN_HI) && w_in_xfer) begin
      w_acc_next = w_acc_init;
    end else if (w_apply) begin
      w_acc_next = w_acc_step;
    end
  end

  // Input handshake: ECHO payload may refill the output register as it drains
  always_comb begin
    ready_o = 1'b0;
    case (r_state)
      S_RESULT:  ready_o = 1'b0;
      S_PAYLOAD: ready_o = w_is_echo ? (!r_valid || ready_i) : !r_valid;
      default:   ready_o = !r_valid;
    endcase
    ready_o = ready_o && r_live;
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;

  // Packet FSM, output register and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_OPCODE;
      r_live    <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= 8'h00;
      r_cnt     <= 16'd0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_res_idx <= '0;
    end else begin
      r_live <= 1'b1;
      r_acc  <= w_acc_next;
      if (w_out_xfer) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        S_OPCODE: begin
          if (w_in_xfer) begin
            r_opcode <= data_i;
            r_state  <= S_RSVD;
          end
        end
        S_RSVD: begin
          if (w_in_xfer) begin
            r_state <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_in_xfer) begin
            r_len_lo <= data_i;
            r_state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_in_xfer) begin
            r_idx     <= '0;
            r_operand <= '0;
            if (w_len_empty) begin
              r_cnt <= 16'd0;
              if (w_is_arith) begin
                r_state   <= S_RESULT;
                r_data    <= w_acc_next[7:0];
                r_valid   <= 1'b1;
                r_res_idx <= '0;
              end else begin
                r_state <= S_OPCODE;
              end
            end else begin
              r_cnt   <= w_len - 16'd4;
              r_state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_in_xfer) begin
            r_cnt <= r_cnt - 16'd1;
            if (w_is_echo) begin
              r_data  <= data_i;
              r_valid <= 1'b1;
            end
            if (w_apply) begin
              r_idx     <= '0;
              r_operand <= '0;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_operand <= w_operand;
            end
            if (w_last) begin
              if (w_is_arith) begin
                r_state   <= S_RESULT;
                r_data    <= w_acc_next[7:0];
                r_valid   <= 1'b1;
                r_res_idx <= '0;
              end else begin
                r_state <= S_OPCODE;
              end
            end
          end
        end
        S_RESULT: begin
          if (w_out_xfer) begin
            if (r_res_idx == IDX_MAX) begin
              r_valid <= 1'b0;
              r_state <= S_OPCODE;
            end else begin
              r_res_idx <= w_next_res_idx;
              r_data    <= w_res_byte;
              r_valid   <= 1'b1;
            end
          end
        end
        default: r_state <= S_OPCODE;
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_parser.md
ALU_CMD_PARSER -- requirements
Module: alu_cmd_parser

Interface
REQ-001 Parameter OPERAND_BYTES, default 4, is the bytes per arithmetic operand; only 4 is supported.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 data_i  input  8  byte from the UART receiver.
REQ-005 valid_i  input  1  data_i valid.
REQ-006 ready_o  output  1  parser accepts data_i this cycle.
REQ-007 data_o  output  8  byte to the UART transmitter.
REQ-008 valid_o  output  1  data_o valid.
REQ-009 ready_i  input  1  transmitter accepts data_o this cycle.

Function
REQ-010 Input transfer occurs when valid_i && ready_o; output transfer occurs when valid_o && ready_i.
REQ-011 Packet format: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8]; LEN is total packet bytes including the 4-byte header; payload = LEN-4 bytes.
REQ-012 The FSM states SHALL be OPCODE, RSVD, LEN_LO, LEN_HI, PAYLOAD, RESULT; each header state advances on one input transfer.
REQ-013 In LEN_HI, LEN<=4 (including 0..3) means an empty payload: go to RESULT for ADD/MUL, otherwise go to OPCODE.
REQ-014 In PAYLOAD, a 16-bit remaining counter is loaded with LEN-4 and decremented per input transfer; on the transfer that brings it to 0: ECHO/unknown -> OPCODE, ADD/MUL -> RESULT.
REQ-015 Opcode 0xEC (ECHO): each payload byte goes into a one-entry output register, valid on the next cycle (1-cycle latency).
REQ-016 During ECHO PAYLOAD, ready_o = !valid_o || ready_i; no byte is dropped or duplicated under backpressure.
REQ-017 Opcode 0xA5 (ADD): payload bytes form little-endian 32-bit operands; the accumulator clears to 0 at LEN_HI, and the sum wraps modulo 2^32.
REQ-018 A trailing partial operand (payload not a multiple of 4) is zero-extended in its upper bytes and then applied.
REQ-019 In RESULT, ready_o=0 and the 4 accumulator bytes are emitted LSB first; the state returns to OPCODE after the 4th output transfer.
REQ-020 Any other opcode: payload bytes are accepted and discarded (ready_o=1) and no output is produced.
REQ-021 In OPCODE/RSVD/LEN_LO/LEN_HI and non-ECHO PAYLOAD, ready_o = 1 once the output register is empty.
REQ-022 data_o SHALL hold stable while valid_o && !ready_i.

Reset
REQ-023 rst returns the state to OPCODE and clears valid_o, data_o, ready_o, the counter and the accumulator to 0 on the next edge, including mid-packet or mid-RESULT; a partial packet is abandoned.
REQ-024 One cycle after rst deasserts, ready_o=1.

Configuration
REQ-025 Macro ALU_CMD_MUL_EN defined: opcode 0xB4 (MUL) is enabled; the accumulator initialises to 1 at LEN_HI, the product wraps modulo 2^32, and operand rules match ADD.
REQ-026 ALU_CMD_MUL_EN undefined: no multiplier is built and 0xB4 is treated as an unknown opcode (REQ-020).

Verification
REQ-027 ECHO: EC 00 06 00 41 42, ready_i=1 -> output 41 42, then idle.
REQ-028 ADD: A5 00 0C 00 01 00 00 00 02 00 00 00 -> output 03 00 00 00.
REQ-029 ADD wrap, ready_i toggling 1/0 each cycle: A5 00 0C 00 FF FF FF FF 01 00 00 00 -> output 00 00 00 00, data_o stable while stalled.
REQ-030 Unknown then ECHO: 11 00 06 00 AA BB EC 00 05 00 5A -> output only 5A.
REQ-031 rst pulse after A5 00 0C 00 01 -> no output; a following EC 00 05 00 33 -> output 33.
REQ-032 With ALU_CMD_MUL_EN: B4 00 0C 00 03 00 00 00 05 00 00 00 -> output 0F 00 00 00; without it -> no output.
